imp_tile_sched: RTL
===================

Name: imp_tile_sched

Overview:
Tile scheduler that sequences the image-processing read engine (mst_imp_r_ch) across a full frame.
- Splits a frame into tiles of cfg_tile_w x cfg_tile_h pixels.
- For each tile, programs the engine task config and fires its start pulse.
- Snoops the engine's R handshakes to detect tile completion before launching the next tile.
- Sits between the CPU-visible config registers and the engine's IMP_* task inputs.

Parameters:
BEAT_BYTES, 4, bytes per 32-bit pixel beat (address step per pixel)
CNT_W, 16, width of beat counter and tile index

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_start  in  1  1T frame start pulse
cfg_abort  in  1  1T abort pulse
cfg_frm_hsize  in  8  frame width, pixels
cfg_frm_vsize  in  8  frame height, rows
cfg_tile_w  in  8  tile width, pixels
cfg_tile_h  in  8  tile height, rows
cfg_src_baddr  in  32  frame base byte address
cfg_adr_pitch  in  9  bytes per frame row
mon_rvalid  in  1  engine R channel valid (snoop)
mon_rready  in  1  engine R channel ready (snoop)
imp_hsize  out  8  tile width to engine
imp_vsize  out  8  tile height to engine
imp_coor_minx  out  8  always 0
imp_coor_miny  out  8  always 0
imp_src_baddr  out  32  tile base address to engine
imp_adr_pitch  out  9  pitch to engine
imp_st  out  1  engine start pulse
busy  out  1  frame in progress
frm_done  out  1  1T pulse, all tiles completed
cfg_err  out  1  1T pulse, illegal config at start
tile_idx  out  CNT_W  index of current tile, row-major

Behaviour:
- Reset and interface: one clock (clk); reset is synchronous and active-high (rst). On reset, every output is 0, the FSM goes to IDLE, and all counters are 0.
- FSM states: IDLE, SETUP, PULSE, GAP, WAIT, NEXT.
- IDLE:
  - On cfg_start, check the config. If any of frm_hsize, frm_vsize, tile_w, tile_h is 0, pulse cfg_err for 1 cycle and stay in IDLE.
  - Otherwise latch all cfg_* into shadow regs, set tx=0, ty=0, tile_idx=0, busy=1, and go to SETUP.
- SETUP (1 cycle):
  - w = min(tile_w, frm_hsize - tx), h = min(tile_h, frm_vsize - ty), using 9-bit math.
  - base = baddr + ty*pitch + tx*BEAT_BYTES, 32-bit wrap-around.
  - Register these onto the imp_* outputs and set expected beats = w*h (16-bit).
  - Go to PULSE.
- PULSE: imp_st=1 for exactly 1 cycle, then go to GAP.
- GAP: imp_st=0 and the beat counter is cleared. Hold 2 cycles, which covers the engine's 2-flop start edge detect. Then go to WAIT.
- WAIT:
  - Beat counter increments on each cycle where mon_rvalid & mon_rready.
  - When count + inc == expected beats, go to NEXT. imp_* stay stable throughout.
- NEXT (1 cycle):
  - tx += tile_w. If tx >= frm_hsize, set tx=0 and ty += tile_h.
  - If ty >= frm_vsize: frm_done=1 for 1 cycle, busy=0, go to IDLE.
  - Otherwise tile_idx++ and go to SETUP.
- Config shadowing: imp_* outputs hold the last tile's values after completion. Changes on cfg_* are ignored while busy.
- cfg_start while busy is ignored.
- Beats outside WAIT are ignored, and are not carried into the next tile.
- cfg_abort in any non-IDLE state:
  - go to IDLE next cycle, busy=0, imp_st=0, no frm_done.
  - Abort has priority over a simultaneous WAIT completion.
- imp_st is never high on two consecutive cycles. Two imp_st pulses are separated by at least 3 low cycles.
- The tile counter and beat counter saturate, no wrap. Total beats are bounded by 255*255 < 2^16.

Decomposition:
- Package imp_pkg:
  - state enum imp_sched_st_e (IDLE, SETUP, PULSE, GAP, WAIT, NEXT);
  - constant IMP_BEAT_BYTES=4;
  - constant IMP_ST_GAP=2.
- Sub-module imp_tile_geom: combinational clip of w/h plus base-address computation, registered in the parent's SETUP state.

Test Plan:
- frm 16x16, tile 8x8, baddr 0x1000, pitch 64, beats returned promptly:
  - 4 tiles with bases 0x1000, 0x1020, 0x1200, 0x1220, each hsize=8, vsize=8;
  - 4 imp_st pulses, each tile waits 64 beats;
  - frm_done 1 cycle after the 256th beat.
- frm 10x5, tile 4x4, pitch 40:
  - tiles (w,h) = (4,4), (4,4), (2,4), (4,1), (4,1), (2,1);
  - tile_idx reaches 5 and frm_done asserts.
- Config error: cfg_tile_w=0 with cfg_start -> cfg_err pulses 1 cycle, busy stays 0, no imp_st.
- Ignored events:
  - cfg_start while busy: no restart, tile_idx unchanged.
  - R beats during PULSE/GAP: not counted; completion occurs after the full 64 WAIT-state beats.
- Abort: cfg_abort mid-WAIT of tile 2 in the same cycle as its final beat -> busy=0 next cycle, no frm_done; a fresh cfg_start restarts at tile_idx 0 with base = baddr.
- Reset: rst asserted during WAIT -> all outputs 0 next cycle, FSM in IDLE.

Source files
------------

// File: rtl/imp_pkg.sv
// Shared types and constants for the image-processing tile scheduler.
// Imported by the scheduler top and its geometry helper.
package imp_pkg;

  localparam int IMP_BEAT_BYTES = 4;
  localparam int IMP_ST_GAP     = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    GAP,
    WAIT,
    NEXT
  } imp_sched_st_e;

endpackage

// File: rtl/imp_tile_geom.sv
// Tile geometry: clips the tile to the frame edge and derives its
// base address and beat count. Purely combinational.
module imp_tile_geom
  import imp_pkg::*;
#(
  parameter int BEAT_BYTES = IMP_BEAT_BYTES
) (
  input  logic [7:0]  tx_i,
  input  logic [7:0]  ty_i,
  input  logic [7:0]  tile_w_i,
  input  logic [7:0]  tile_h_i,
  input  logic [7:0]  frm_hsize_i,
  input  logic [7:0]  frm_vsize_i,
  input  logic [31:0] baddr_i,
  input  logic [8:0]  pitch_i,
  output logic [7:0]  w_o,
  output logic [7:0]  h_o,
  output logic [31:0] base_o,
  output logic [15:0] beats_o
);

  logic [8:0]  rem_w;
  logic [8:0]  rem_h;
  logic [16:0] row_off;
  logic [31:0] col_off;

  always_comb begin
    rem_w   = {1'b0, frm_hsize_i} - {1'b0, tx_i};
    rem_h   = {1'b0, frm_vsize_i} - {1'b0, ty_i};
    w_o     = ({1'b0, tile_w_i} < rem_w) ? tile_w_i : rem_w[7:0];
    h_o     = ({1'b0, tile_h_i} < rem_h) ? tile_h_i : rem_h[7:0];
    beats_o = {8'd0, w_o} * {8'd0, h_o};
    row_off = {9'd0, ty_i} * {8'd0, pitch_i};
    col_off = {24'd0, tx_i} * 32'(BEAT_BYTES);
    base_o  = baddr_i + {15'd0, row_off} + col_off;
  end

endmodule

// File: rtl/imp_tile_sched.sv
// Frame tile scheduler: walks tiles row-major, programs the read
// engine per tile and waits for its R beats before moving on.
module imp_tile_sched
  import imp_pkg::*;
#(
  parameter int BEAT_BYTES = IMP_BEAT_BYTES,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_abort,
  input  logic [7:0]       cfg_frm_hsize,
  input  logic [7:0]       cfg_frm_vsize,
  input  logic [7:0]       cfg_tile_w,
  input  logic [7:0]       cfg_tile_h,
  input  logic [31:0]      cfg_src_baddr,
  input  logic [8:0]       cfg_adr_pitch,
  input  logic             mon_rvalid,
  input  logic             mon_rready,
  output logic [7:0]       imp_hsize,
  output logic [7:0]       imp_vsize,
  output logic [7:0]       imp_coor_minx,
  output logic [7:0]       imp_coor_miny,
  output logic [31:0]      imp_src_baddr,
  output logic [8:0]       imp_adr_pitch,
  output logic             imp_st,
  output logic             busy,
  output logic             frm_done,
  output logic             cfg_err,
  output logic [CNT_W-1:0] tile_idx
);

  imp_sched_st_e    state_q, state_d;
  logic [7:0]       hs_q, hs_d, vs_q, vs_d;
  logic [7:0]       tw_q, tw_d, th_q, th_d;
  logic [31:0]      ba_q, ba_d;
  logic [8:0]       pitch_q, pitch_d;
  logic [7:0]       tx_q, tx_d, ty_q, ty_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] exp_q, exp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       gap_q, gap_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [7:0]       ohs_q, ohs_d, ovs_q, ovs_d;
  logic [31:0]      obase_q, obase_d;
  logic [8:0]       opitch_q, opitch_d;

  logic [7:0]       g_w, g_h;
  logic [31:0]      g_base;
  logic [15:0]      g_beats;
  logic             inc, cfg_bad, wrap, last;
  logic [8:0]       nx, ny;
  logic [CNT_W:0]   cnt_sum;

  imp_tile_geom #(
    .BEAT_BYTES(BEAT_BYTES)
  ) u_geom (
    .tx_i       (tx_q),
    .ty_i       (ty_q),
    .tile_w_i   (tw_q),
    .tile_h_i   (th_q),
    .frm_hsize_i(hs_q),
    .frm_vsize_i(vs_q),
    .baddr_i    (ba_q),
    .pitch_i    (pitch_q),
    .w_o        (g_w),
    .h_o        (g_h),
    .base_o     (g_base),
    .beats_o    (g_beats)
  );

  assign inc     = mon_rvalid & mon_rready;
  assign cfg_bad = (cfg_frm_hsize == 8'd0) | (cfg_frm_vsize == 8'd0)
                 | (cfg_tile_w == 8'd0) | (cfg_tile_h == 8'd0);
  assign nx      = {1'b0, tx_q} + {1'b0, tw_q};
  assign ny      = {1'b0, ty_q} + {1'b0, th_q};
  assign wrap    = nx >= {1'b0, hs_q};
  assign last    = wrap & (ny >= {1'b0, vs_q});
  assign cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(inc);

  always_comb begin
    state_d  = state_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    tw_d     = tw_q;
    th_d     = th_q;
    ba_d     = ba_q;
    pitch_d  = pitch_q;
    tx_d     = tx_q;
    ty_d     = ty_q;
    idx_d    = idx_q;
    exp_d    = exp_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    busy_d   = busy_q;
    err_d    = 1'b0;
    ohs_d    = ohs_q;
    ovs_d    = ovs_q;
    obase_d  = obase_q;
    opitch_d = opitch_q;
    // abort wins over anything the current state wants to do
    if (cfg_abort && (state_q != IDLE)) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cfg_start) begin
            if (cfg_bad) begin
              err_d = 1'b1;
            end else begin
              hs_d    = cfg_frm_hsize;
              vs_d    = cfg_frm_vsize;
              tw_d    = cfg_tile_w;
              th_d    = cfg_tile_h;
              ba_d    = cfg_src_baddr;
              pitch_d = cfg_adr_pitch;
              tx_d    = 8'd0;
              ty_d    = 8'd0;
              idx_d   = '0;
              busy_d  = 1'b1;
              state_d = SETUP;
            end
          end
        end
        SETUP: begin
          ohs_d    = g_w;
          ovs_d    = g_h;
          obase_d  = g_base;
          opitch_d = pitch_q;
          exp_d    = CNT_W'(g_beats);
          state_d  = PULSE;
        end
        PULSE: begin
          gap_d   = 2'd0;
          cnt_d   = '0;
          state_d = GAP;
        end
        GAP: begin
          cnt_d = '0;
          if (gap_q == 2'(IMP_ST_GAP - 1)) state_d = WAIT;
          else gap_d = gap_q + 2'd1;
        end
        WAIT: begin
          cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
          if (cnt_sum == {1'b0, exp_q}) state_d = NEXT;
        end
        NEXT: begin
          if (wrap) begin
            tx_d = 8'd0;
            ty_d = ny[7:0];
          end else begin
            tx_d = nx[7:0];
          end
          if (last) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            if (idx_q != '1) idx_d = idx_q + 1'b1;
            state_d = SETUP;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hs_q     <= '0;
      vs_q     <= '0;
      tw_q     <= '0;
      th_q     <= '0;
      ba_q     <= '0;
      pitch_q  <= '0;
      tx_q     <= '0;
      ty_q     <= '0;
      idx_q    <= '0;
      exp_q    <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      ohs_q    <= '0;
      ovs_q    <= '0;
      obase_q  <= '0;
      opitch_q <= '0;
    end else begin
      state_q  <= state_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      tw_q     <= tw_d;
      th_q     <= th_d;
      ba_q     <= ba_d;
      pitch_q  <= pitch_d;
      tx_q     <= tx_d;
      ty_q     <= ty_d;
      idx_q    <= idx_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      ohs_q    <= ohs_d;
      ovs_q    <= ovs_d;
      obase_q  <= obase_d;
      opitch_q <= opitch_d;
    end
  end

  assign imp_hsize     = ohs_q;
  assign imp_vsize     = ovs_q;
  assign imp_coor_minx = 8'd0;
  assign imp_coor_miny = 8'd0;
  assign imp_src_baddr = obase_q;
  assign imp_adr_pitch = opitch_q;
  assign imp_st        = (state_q == PULSE);
  assign busy          = busy_q;
  assign frm_done      = (state_q == NEXT) & last & ~cfg_abort;
  assign cfg_err       = err_q;
  assign tile_idx      = idx_q;

endmodule
